// File: rtl/fp_pkg.sv
// Shared single-precision constants and field layouts for the floating-point adder datapath.
package fp_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam int MANT_W   = 24;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   // Contents of the first pipeline register: the raw beat plus its leading-zero count.
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
      logic [4:0]  lz;
      logic        special;
      logic [31:0] special_val;
   } s1_beat_t;

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero count of a 24-bit mantissa field; an all-zero field reports 23, the largest useful shift.
module fp_lzc24
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0] value,
   output logic [4:0]        count
);

   // Scanning upward lets the highest set bit have the final say.
   always_comb begin
      count = 5'd23;
      for (int i = 0; i < MANT_W; i++) begin
         if (value[i]) count = 5'(23 - i);
      end
   end

endmodule

// File: rtl/fp_add_normalize.sv
// Normalize, round-to-nearest-even and pack stage of the sequential single-precision adder (2-stage pipeline).
// Define FP_NORM_SUBNORMAL_EN to emit subnormal results instead of flushing underflow to signed zero.
module fp_add_normalize
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [24:0] in_mant,
   input  logic [2:0]  in_grs,
   input  logic        in_special,
   input  logic [31:0] in_special_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_overflow,
   output logic        out_underflow,
   output logic        out_inexact
);

   localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);

   s1_beat_t          s1_q;
   logic              s1_valid;
   logic              adv1;
   logic              adv2;
   logic [4:0]        lz;

   logic [4:0]        sh;
   logic [25:0]       vec_l;
   logic [23:0]       m;
   logic              g, r, s;
   logic              round_up;
   logic [24:0]       m_rnd;
   logic signed [9:0] e;
   fp32_t             res;
   logic              ovf, unf, inx;

   // Handshake: a beat moves across an interface on a rising edge where valid && ready; ready never
   // depends on valid, and a stage advances when it is empty or the stage after it is advancing.
   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   fp_lzc24 u_lzc (
      .value (in_mant[23:0]),
      .count (lz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= '{sign: in_sign, exp: in_exp, mant: in_mant, grs: in_grs, lz: lz,
                      special: in_special, special_val: in_special_val};
         end
      end
   end

`ifdef FP_NORM_SUBNORMAL_EN
   logic [9:0] exp_m1;
   assign exp_m1 = {2'b00, s1_q.exp} - 10'd1;
`endif

   always_comb begin
      sh = s1_q.lz;
`ifdef FP_NORM_SUBNORMAL_EN
      // Never shift the exponent below 1; what is left unnormalized becomes a subnormal.
      if ({5'd0, s1_q.lz} > exp_m1) sh = exp_m1[4:0];
`endif
      vec_l = {s1_q.mant[23:0], s1_q.grs[2:1]} << sh;
      if (s1_q.mant[24]) begin
         m = s1_q.mant[24:1];
         g = s1_q.mant[0];
         r = s1_q.grs[2];
         s = s1_q.grs[1] | s1_q.grs[0];
         e = $signed({2'b00, s1_q.exp}) + 10'sd1;
      end else begin
         m = vec_l[25:2];
         g = vec_l[1];
         r = vec_l[0];
         s = s1_q.grs[0];
         e = $signed({2'b00, s1_q.exp}) - $signed({5'd0, sh});
      end

      round_up = g & (r | s | m[0]);
      inx      = g | r | s;
      m_rnd    = {1'b0, m} + {24'd0, round_up};
      if (m_rnd[24]) begin
         m_rnd = {1'b0, m_rnd[24:1]};
         e     = e + 10'sd1;
      end

      ovf = 1'b0;
      unf = 1'b0;
      res = '{sign: s1_q.sign, exp: e[7:0], frac: m_rnd[22:0]};
      if (s1_q.special) begin
         res = s1_q.special_val;
         inx = 1'b0;
      end else if (s1_q.mant == 25'd0 && s1_q.grs == 3'd0) begin
         // Exact cancellation rounds to +0 under round-to-nearest-even.
         res = '0;
         inx = 1'b0;
      end else if (e >= EXP_OVF) begin
         res = '{sign: s1_q.sign, exp: 8'hFF, frac: 23'd0};
         ovf = 1'b1;
         inx = 1'b1;
      end
`ifdef FP_NORM_SUBNORMAL_EN
      else if (!m_rnd[23]) begin
         res.exp = 8'd0;
         unf     = inx;
      end
`else
      else if (e <= 10'sd0) begin
         res = '{sign: s1_q.sign, exp: 8'd0, frac: 23'd0};
         unf = 1'b1;
         inx = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result    <= res;
            out_overflow  <= ovf;
            out_underflow <= unf;
            out_inexact   <= inx;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed corner cases, backpressure, reset and random beats
// scored against an arithmetic reference model (honours FP_NORM_SUBNORMAL_EN like the design).
module tb_fp_add_normalize;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_mant;
   logic [2:0]  in_grs;
   logic        in_special;
   logic [31:0] in_special_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   // Scoreboard entries are {result, overflow, underflow, inexact}.
   logic [34:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_acc    = 0;
   logic        use_fixed = 1'b0;
   logic [34:0] fixed_exp = '0;

   fp_add_normalize dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exp         (in_exp),
      .in_mant        (in_mant),
      .in_grs         (in_grs),
      .in_special     (in_special),
      .in_special_val (in_special_val),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_overflow   (out_overflow),
      .out_underflow  (out_underflow),
      .out_inexact    (out_inexact)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [34:0] got, input logic [34:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [34:0] model(input logic sgn, input logic [7:0] ex, input logic [24:0] mt,
                                         input logic [2:0] grs, input logic sp, input logic [31:0] sv);
      longint unsigned v, keep;
      int              e, sh, lead;
      bit              st, g, r, up, inx, ovf, unf, hidden;
      logic [31:0]     res;
      if (sp) return {sv, 3'b000};
      if (mt == 0 && grs == 0) return 35'd0;
      v  = longint'(mt) * 4 + longint'(grs[2]) * 2 + longint'(grs[1]);
      st = grs[0];
      e  = int'(ex);
      if (mt[24]) begin
         st = st | v[0];
         v  = v / 2;
         e  = e + 1;
      end else begin
         lead = -1;
         for (int i = 0; i < 24; i++) if (mt[i]) lead = i;
         sh = (lead < 0) ? 23 : 23 - lead;
`ifdef FP_NORM_SUBNORMAL_EN
         if (sh > e - 1) sh = e - 1;
`endif
         v = (v << sh) % (64'd1 << 26);
         e = e - sh;
      end
      keep = v / 4;
      g    = v[1];
      r    = v[0];
      inx  = g | r | st;
      up   = g && (r || st || (keep % 2 == 1));
      keep = keep + longint'(up);
      if (keep >= (64'd1 << 24)) begin
         keep = keep / 2;
         e    = e + 1;
      end
      hidden = keep >= (64'd1 << 23);
      ovf = 0;
      unf = 0;
      res = {sgn, 8'(e), 23'(keep % (64'd1 << 23))};
      if (e >= 255) begin
         res = {sgn, 8'hFF, 23'd0};
         ovf = 1;
         inx = 1;
      end
`ifdef FP_NORM_SUBNORMAL_EN
      else if (!hidden) begin
         res = {sgn, 8'd0, 23'(keep)};
         unf = inx;
      end
`else
      else if (e <= 0) begin
         res = {sgn, 31'd0};
         unf = 1;
         inx = 1;
      end
`endif
      return {res, ovf, unf, inx};
   endfunction

   // ---------------- scoreboard monitor (samples on the falling edge) ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            n_acc++;
            if (use_fixed) exp_q.push_back(fixed_exp);
            else exp_q.push_back(model(in_sign, in_exp, in_mant, in_grs, in_special, in_special_val));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_with_empty_queue", {34'd0, out_valid}, 35'd0);
            else check("result", {out_result, out_overflow, out_underflow, out_inexact}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic sgn, input logic [7:0] ex, input logic [24:0] mt, input logic [2:0] grs,
                       input logic sp, input logic [31:0] sv);
      int budget = 0;
      in_valid = 1'b1; in_sign = sgn; in_exp = ex; in_mant = mt; in_grs = grs;
      in_special = sp; in_special_val = sv;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) check("accept_timeout", {34'd0, in_ready}, 35'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_fixed(input logic [7:0] ex, input logic [24:0] mt, input logic [2:0] grs,
                             input logic [34:0] want);
      use_fixed = 1'b1;
      fixed_exp = want;
      send(1'b0, ex, mt, grs, 1'b0, 32'd0);
      use_fixed = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
         @(posedge clk);
         budget++;
      end
      #1;
      check("drain", 35'(exp_q.size()), 35'd0);
   endtask

   task automatic send_random();
      logic [24:0] mt;
      logic [7:0]  ex;
      int          p, mode;
      mode = $urandom_range(0, 19);
      if (mode < 5) mt = {1'b1, 24'($urandom)};
      else if (mode == 5) mt = 25'd0;
      else begin
         p  = $urandom_range(0, 23);
         mt = (25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1));
      end
      case ($urandom_range(0, 3))
         0:       ex = 8'($urandom_range(1, 30));
         1:       ex = 8'($urandom_range(230, 254));
         default: ex = 8'($urandom_range(1, 254));
      endcase
      send(1'($urandom), ex, mt, (mode == 5 && $urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom),
           $urandom_range(0, 19) == 0, $urandom);
   endtask

   // ---------------- test sequence ----------------
   logic [34:0] held;
   logic        rand_done;

   initial begin
      in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd1; in_mant = '0; in_grs = '0;
      in_special = 1'b0; in_special_val = '0; out_ready = 1'b1; rand_done = 1'b0;
      do_reset();
      @(negedge clk);
      check("reset_out_valid", {34'd0, out_valid}, 35'd0);
      check("reset_outputs", {out_result, out_overflow, out_underflow, out_inexact}, 35'd0);
      check("reset_in_ready", {34'd0, in_ready}, 35'd1);

      // Latency: accepted at one edge, result visible after the next one.
      @(posedge clk); #1;
      send_fixed(8'd127, 25'h1000000, 3'b000, {32'h40000000, 3'b000});
      @(negedge clk);
      check("latency_not_early", {34'd0, out_valid}, 35'd0);
      @(negedge clk);
      check("latency_two", {34'd0, out_valid}, 35'd1);
      drain();

      send_fixed(8'd127, 25'h0000001, 3'b000, {32'h34000000, 3'b000});
      send_fixed(8'd127, 25'h0000000, 3'b000, {32'h00000000, 3'b000});
      send_fixed(8'd127, 25'h0FFFFFF, 3'b100, {32'h40000000, 3'b001});
      send_fixed(8'd254, 25'h1000000, 3'b000, {32'h7F800000, 3'b101});
`ifdef FP_NORM_SUBNORMAL_EN
      send_fixed(8'd10, 25'h0000001, 3'b000, {32'h00000200, 3'b000});
`else
      send_fixed(8'd10, 25'h0000001, 3'b000, {32'h00000000, 3'b011});
`endif
      send(1'b1, 8'd5, 25'h0ABCDEF, 3'b011, 1'b1, 32'h7FC00001);
      drain();

      // Backpressure: three beats offered against a stalled consumer.
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            send_fixed(8'd127, 25'h1000000, 3'b000, {32'h40000000, 3'b000});
            send_fixed(8'd127, 25'h0000001, 3'b000, {32'h34000000, 3'b000});
            send_fixed(8'd127, 25'h0FFFFFF, 3'b100, {32'h40000000, 3'b001});
         end
         begin
            repeat (6) @(negedge clk);
            check("bp_in_ready_low", {34'd0, in_ready}, 35'd0);
            check("bp_accepts", 35'(n_acc), 35'd2);
            held = {out_result, out_overflow, out_underflow, out_inexact};
            check("bp_head", held, {32'h40000000, 3'b000});
            repeat (3) @(negedge clk);
            check("bp_hold", {out_result, out_overflow, out_underflow, out_inexact}, held);
            check("bp_valid_hold", {34'd0, out_valid}, 35'd1);
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();
      check("bp_total", 35'(n_acc), 35'd3);

      // Reset while a beat is in flight discards it.
      out_ready = 1'b0;
      send(1'b0, 8'd100, 25'h0800000, 3'b000, 1'b0, 32'd0);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      check("midreset_out_valid", {34'd0, out_valid}, 35'd0);
      check("midreset_in_ready", {34'd0, in_ready}, 35'd1);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("midreset_no_output", {34'd0, out_valid}, 35'd0);

      // Random beats with random consumer stalls.
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send_random();
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
